// File: rtl/rc5_pkg.sv
// Shared RC5 definitions: FSM state encodings for encipher/decipher and magic constants.
// Latency: n/a (package only).
// Backpressure: n/a.
package rc5_pkg;

    // Encipher sequence: load, prime key reads, initial add, then 9 states per round.
    typedef enum logic [3:0] {
        ENC_IDLE,
        ENC_INIT,
        ENC_WAIT_ADDR,
        ENC_READ_DATA,
        ENC_ADD_INIT,
        ENC_WAIT_ADDR2,
        ENC_READ_DATA2,
        ENC_XOR_A,
        ENC_ROT_A,
        ENC_ADD_A,
        ENC_XOR_B,
        ENC_ROT_B,
        ENC_ADD_B,
        ENC_NEXT_ROUND,
        ENC_DONE
    } enc_state_t;

    // Decipher walks the rounds backwards and finishes with the initial subtract.
    typedef enum logic [3:0] {
        DEC_IDLE,
        DEC_INIT,
        DEC_WAIT_ADDR,
        DEC_READ_DATA,
        DEC_SUB_B,
        DEC_ROT_B,
        DEC_XOR_B,
        DEC_SUB_A,
        DEC_ROT_A,
        DEC_XOR_A,
        DEC_NEXT_ROUND,
        DEC_SUB_INIT,
        DEC_DONE
    } dec_state_t;

    // RC5 magic constants (odd((e-2)*2^W) and odd((phi-1)*2^W)) for key expansion.
    localparam logic [15:0] P16 = 16'hB7E1;
    localparam logic [15:0] Q16 = 16'h9E37;
    localparam logic [31:0] P32 = 32'hB7E15163;
    localparam logic [31:0] Q32 = 32'h9E3779B9;
    localparam logic [63:0] P64 = 64'hB7E151628AED2A6B;
    localparam logic [63:0] Q64 = 64'h9E3779B97F4A7C15;

endpackage

// File: rtl/encipher_barrel_shifter.sv
// Combinational W-bit rotator: dir=0 rotates left, dir=1 rotates right, by amount mod W.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; ports: data/amount/dir in, result out.
module encipher_barrel_shifter #(
    parameter int W = 32
) (
    input  logic [W-1:0]         data,
    input  logic [$clog2(W)-1:0] amount,
    input  logic                 dir,
    output logic [W-1:0]         result
);

    localparam int ROT_VALUE = $clog2(W);

    // Complementary shift; amount=0 gives a shift of W, which yields zero and
    // leaves the rotate equal to the input.
    logic [ROT_VALUE:0] inv_amount;
    logic [W-1:0]       rot_left;
    logic [W-1:0]       rot_right;

    assign inv_amount = (ROT_VALUE+1)'(W) - {1'b0, amount};
    assign rot_left   = (data << amount) | (data >> inv_amount);
    assign rot_right  = (data >> amount) | (data << inv_amount);
    assign result     = dir ? rot_right : rot_left;

endmodule

// File: rtl/encipher.sv
// RC5 encryption engine: one rotate per step, 9 cycles per round, key table via two sync-read ports.
// Latency: oDone and final A,B registered 4+9R edges after IDLE first sees iStart high.
// Backpressure: none; iStart is a held level (low = reset), oDone sticky until iStart falls or rst.
// Ports: clk, rst (sync, active-high), iStart, iA/iB plaintext, oS_address1/2 -> iS_sub_i1/2
//        key words (1-cycle read), oA_encipher/oB_encipher working/result words, oDone.
module encipher
    import rc5_pkg::*;
#(
    parameter int W = 32,
    parameter int R = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          iStart,
    input  logic [W-1:0]                  iA,
    input  logic [W-1:0]                  iB,
    output logic [$clog2(2*(R+1))-1:0]    oS_address1,
    output logic [$clog2(2*(R+1))-1:0]    oS_address2,
    input  logic [W-1:0]                  iS_sub_i1,
    input  logic [W-1:0]                  iS_sub_i2,
    output logic [W-1:0]                  oA_encipher,
    output logic [W-1:0]                  oB_encipher,
    output logic                          oDone
);

    localparam int ROT_VALUE = $clog2(W);
    localparam int T         = 2*(R+1);
    localparam int T_LENGTH  = $clog2(T);
    localparam int CNT_BITS  = $clog2(R+1);

    enc_state_t           state;
    enc_state_t           next_state;
    logic [CNT_BITS-1:0]  round;
    logic [W-1:0]         rot_data;
    logic [ROT_VALUE-1:0] rot_amt;
    logic [W-1:0]         rot_out;
    logic                 last_round;
    logic [T_LENGTH-1:0]  next_even;

    // Rotate operand is captured one state ahead so the rotator sees registered inputs.
    encipher_barrel_shifter #(.W(W)) u_rot (
        .data   (rot_data),
        .amount (rot_amt),
        .dir    (1'b0),
        .result (rot_out)
    );

    assign last_round = (round == CNT_BITS'(R));
    assign next_even  = (T_LENGTH'(round) + T_LENGTH'(1)) << 1;

    always_ff @(posedge clk) begin
        if (rst || !iStart) begin
            state <= ENC_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ENC_IDLE:       if (iStart) next_state = ENC_INIT;
            ENC_INIT:       next_state = ENC_WAIT_ADDR;
            ENC_WAIT_ADDR:  next_state = ENC_READ_DATA;
            ENC_READ_DATA:  next_state = ENC_ADD_INIT;
            ENC_ADD_INIT:   next_state = ENC_WAIT_ADDR2;
            ENC_WAIT_ADDR2: next_state = ENC_READ_DATA2;
            ENC_READ_DATA2: next_state = ENC_XOR_A;
            ENC_XOR_A:      next_state = ENC_ROT_A;
            ENC_ROT_A:      next_state = ENC_ADD_A;
            ENC_ADD_A:      next_state = ENC_XOR_B;
            ENC_XOR_B:      next_state = ENC_ROT_B;
            ENC_ROT_B:      next_state = ENC_ADD_B;
            ENC_ADD_B:      next_state = ENC_NEXT_ROUND;
            ENC_NEXT_ROUND: next_state = last_round ? ENC_DONE : ENC_WAIT_ADDR2;
            ENC_DONE:       next_state = ENC_DONE;
            default:        next_state = ENC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !iStart) begin
            oS_address1 <= '0;
            oS_address2 <= T_LENGTH'(1);
            oA_encipher <= '0;
            oB_encipher <= '0;
            round       <= CNT_BITS'(1);
            rot_data    <= '0;
            rot_amt     <= '0;
            oDone       <= 1'b0;
        end else begin
            case (state)
                ENC_INIT: begin
                    oA_encipher <= iA;
                    oB_encipher <= iB;
                end
                ENC_ADD_INIT: begin
                    oA_encipher <= oA_encipher + iS_sub_i1;
                    oB_encipher <= oB_encipher + iS_sub_i2;
                    // Round 1 keys; fetched during WAIT_ADDR2/READ_DATA2.
                    oS_address1 <= T_LENGTH'(2);
                    oS_address2 <= T_LENGTH'(3);
                end
                ENC_XOR_A: begin
                    oA_encipher <= oA_encipher ^ oB_encipher;
                    rot_data    <= oA_encipher ^ oB_encipher;
                    rot_amt     <= oB_encipher[ROT_VALUE-1:0];
                end
                ENC_ROT_A: oA_encipher <= rot_out;
                ENC_ADD_A: oA_encipher <= oA_encipher + iS_sub_i1;
                ENC_XOR_B: begin
                    oB_encipher <= oB_encipher ^ oA_encipher;
                    rot_data    <= oB_encipher ^ oA_encipher;
                    rot_amt     <= oA_encipher[ROT_VALUE-1:0];
                end
                ENC_ROT_B: oB_encipher <= rot_out;
                ENC_ADD_B: oB_encipher <= oB_encipher + iS_sub_i2;
                ENC_NEXT_ROUND: begin
                    // Counter stops at R, so it never needs to hold R+1.
                    if (last_round) begin
                        oDone <= 1'b1;
                    end else begin
                        round       <= round + CNT_BITS'(1);
                        oS_address1 <= next_even;
                        oS_address2 <= next_even | T_LENGTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_encipher.sv
// Directed bench for encipher: RC5-32/12 instance plus an R=1 instance, synchronous key-table model.
// Latency: checks oDone at edge 4+9R relative to the first IDLE edge with iStart high.
// Backpressure: none; every wait is a fixed cycle count.
module tb_encipher;
    import rc5_pkg::*;

    int checks   = 0;
    int failures = 0;

    logic        clk;
    logic        rst;

    // RC5-32/12 instance
    logic        start;
    logic [31:0] a_in, b_in;
    logic [4:0]  addr1, addr2;
    logic [31:0] s_dat1, s_dat2;
    logic [31:0] a_out, b_out;
    logic        done;
    logic [31:0] s_tab [0:31];

    // RC5-32/1 instance with all-zero key table
    logic        start_r1;
    logic [31:0] a_r1, b_r1;
    logic [1:0]  addr1_r1, addr2_r1;
    logic [31:0] s1_r1, s2_r1;
    logic [31:0] a_out_r1, b_out_r1;
    logic        done_r1;

    encipher #(.W(32), .R(12)) u_dut (
        .clk(clk), .rst(rst), .iStart(start), .iA(a_in), .iB(b_in),
        .oS_address1(addr1), .oS_address2(addr2),
        .iS_sub_i1(s_dat1), .iS_sub_i2(s_dat2),
        .oA_encipher(a_out), .oB_encipher(b_out), .oDone(done)
    );

    encipher #(.W(32), .R(1)) u_dut_r1 (
        .clk(clk), .rst(rst), .iStart(start_r1), .iA(a_r1), .iB(b_r1),
        .oS_address1(addr1_r1), .oS_address2(addr2_r1),
        .iS_sub_i1(s1_r1), .iS_sub_i2(s2_r1),
        .oA_encipher(a_out_r1), .oB_encipher(b_out_r1), .oDone(done_r1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read key table: data valid one cycle after the address.
    always @(posedge clk) begin
        s_dat1 <= s_tab[addr1];
        s_dat2 <= s_tab[addr2];
        s1_r1  <= 32'h0;
        s2_r1  <= 32'h0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [31:0] s);
        int n;
        n = int'(s & 32'd31);
        if (n == 0) return x;
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [31:0] s);
        int n;
        n = int'(s & 32'd31);
        if (n == 0) return x;
        return (x >> n) | (x << (32 - n));
    endfunction

    // Standard RC5 key schedule for a 16-byte all-zero key.
    task automatic expand_zero_key();
        logic [31:0] l [0:3];
        logic [31:0] ka, kb;
        int i, j;
        for (int k = 0; k < 4; k++) l[k] = 32'h0;
        for (int k = 0; k < 32; k++) s_tab[k] = 32'h0;
        s_tab[0] = P32;
        for (int k = 1; k < 26; k++) s_tab[k] = s_tab[k-1] + Q32;
        ka = 0; kb = 0; i = 0; j = 0;
        for (int k = 0; k < 78; k++) begin
            s_tab[i] = rotl32(s_tab[i] + ka + kb, 32'd3);
            ka = s_tab[i];
            l[j] = rotl32(l[j] + ka + kb, ka + kb);
            kb = l[j];
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
    endtask

    function automatic logic [63:0] enc_model(input logic [31:0] pa, input logic [31:0] pb);
        logic [31:0] ea, eb;
        ea = pa + s_tab[0];
        eb = pb + s_tab[1];
        for (int r = 1; r <= 12; r++) begin
            ea = rotl32(ea ^ eb, eb) + s_tab[2*r];
            eb = rotl32(eb ^ ea, ea) + s_tab[2*r+1];
        end
        return {ea, eb};
    endfunction

    function automatic logic [63:0] dec_model(input logic [31:0] ca, input logic [31:0] cb);
        logic [31:0] da, db;
        da = ca; db = cb;
        for (int r = 12; r >= 1; r--) begin
            db = rotr32(db - s_tab[2*r+1], da) ^ da;
            da = rotr32(da - s_tab[2*r], db) ^ db;
        end
        return {da - s_tab[0], db - s_tab[1]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a"},    64'(a_out), 64'h0);
        check({tag, "_b"},    64'(b_out), 64'h0);
        check({tag, "_addr"}, 64'({addr1, addr2}), 64'({5'd0, 5'd1}));
        check({tag, "_done"}, 64'(done), 64'h0);
    endtask

    initial begin
        logic [31:0] pa, pb;
        int          ri;

        rst = 1'b1; start = 1'b0; a_in = 0; b_in = 0;
        start_r1 = 1'b0; a_r1 = 0; b_r1 = 0;
        expand_zero_key();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_r1_addr", 64'({addr1_r1, addr2_r1}), 64'({2'd0, 2'd1}));

        // R=1, zero key: exercises rotate-by-0 (A) and rotate-by-1 (B).
        @(negedge clk);
        rst = 1'b0;
        a_r1 = 32'h1; b_r1 = 32'h0; start_r1 = 1'b1;
        repeat (13) @(posedge clk);
        #1;
        check("r1_done_edge12", 64'(done_r1), 64'h0);
        @(posedge clk);
        #1;
        check("r1_done_edge13", 64'(done_r1), 64'h1);
        check("r1_a", 64'(a_out_r1), 64'h1);
        check("r1_b", 64'(b_out_r1), 64'h2);
        @(negedge clk);
        start_r1 = 1'b0;

        // RC5-32/12 zero key, zero plaintext, with per-edge address and oDone trace.
        @(negedge clk);
        a_in = 32'h0; b_in = 32'h0; start = 1'b1;
        for (int e = 0; e <= 112; e++) begin
            @(posedge clk);
            #1;
            if (e == 2) begin
                a_in = 32'hDEADBEEF;
                b_in = 32'h12345678;
            end
            ri = (e < 4) ? 0 : ((e - 4) / 9 + 1);
            if (ri > 12) ri = 12;
            check("addr_trace", 64'({addr1, addr2}), 64'({5'(2*ri), 5'(2*ri+1)}));
            check("done_trace", 64'(done), 64'(e >= 112));
        end
        check("zero_key_a", 64'(a_out), 64'hEEDBA521);
        check("zero_key_b", 64'(b_out), 64'h6D8F4B15);
        check("zero_key_model", 64'({a_out, b_out}), enc_model(32'h0, 32'h0));

        // iStart dropped after edge 50, sampled low on edge 51.
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a_in = 32'h0; b_in = 32'h0; start = 1'b1;
        repeat (51) @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("drop");
        @(negedge clk);
        start = 1'b1;
        repeat (112) @(posedge clk);
        #1;
        check("drop_rerun_edge111", 64'(done), 64'h0);
        @(posedge clk);
        #1;
        check("drop_rerun_done", 64'(done), 64'h1);
        check("drop_rerun_ab", 64'({a_out, b_out}), 64'hEEDBA5216D8F4B15);

        // rst pulse while in DONE with iStart held high.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_in_done");
        @(negedge clk);
        rst = 1'b0;
        repeat (112) @(posedge clk);
        #1;
        check("rst_rerun_edge111", 64'(done), 64'h0);
        @(posedge clk);
        #1;
        check("rst_rerun_done", 64'(done), 64'h1);
        check("rst_rerun_ab", 64'({a_out, b_out}), 64'hEEDBA5216D8F4B15);

        // Random key tables and plaintexts; first two force round-1 rotate amounts 31 and 0.
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 26; k++) s_tab[k] = $urandom;
            pa = $urandom;
            pb = $urandom;
            if (t == 0) pb = 32'h1F - s_tab[1];
            if (t == 1) pb = 32'h0 - s_tab[1];
            @(negedge clk);
            a_in = pa; b_in = pb; start = 1'b1;
            repeat (113) @(posedge clk);
            #1;
            check("rand_done", 64'(done), 64'h1);
            check("rand_model", 64'({a_out, b_out}), enc_model(pa, pb));
            check("rand_roundtrip", dec_model(a_out, b_out), 64'({pa, pb}));
        end

        @(negedge clk);
        start = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encipher.md
Name: encipher

Overview:
- RC5 encryption engine, W-bit words, R rounds, multi-cycle FSM with one rotate per step.
- Takes a plaintext word pair A,B and reads the expanded key table S[0..2R+1] through two synchronous-read address ports.
- Produces ciphertext A,B and raises oDone; it is the forward-direction counterpart of the decipher block and shares its key-table interface and iStart convention.

Parameters:
- W, 32, word width (16/32/64).
- R, 12, number of rounds.
- Derived, not overridable: ROT_VALUE = $clog2(W); T = 2*(R+1); T_LENGTH = $clog2(T); CNT_BITS = $clog2(R+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- iStart  in  1  level enable; must be held high for the whole operation; low acts as reset.
- iA  in  W  plaintext word A; sampled in INIT.
- iB  in  W  plaintext word B; sampled in INIT.
- oS_address1  out  T_LENGTH  key-table address of the even word S[2i].
- oS_address2  out  T_LENGTH  key-table address of the odd word S[2i+1].
- iS_sub_i1  in  W  S[oS_address1]; valid one cycle after the address is presented.
- iS_sub_i2  in  W  S[oS_address2]; valid one cycle after the address is presented.
- oA_encipher  out  W  working/result word A.
- oB_encipher  out  W  working/result word B.
- oDone  out  1  result valid; sticky until iStart falls or rst.

Behaviour:
- Reset (rst=1 or iStart=0 at a clock edge): state=IDLE, oS_address1=0, oS_address2=1, oA/oB=0, round=1, rotate regs=0, oDone=0.
- Algorithm: A=A+S[0]; B=B+S[1]; for i=1..R: A=((A^B)<<<B)+S[2i]; B=((B^A)<<<A)+S[2i+1]. All adds are mod 2^W. Rotate amount is the low ROT_VALUE bits only.
- States and transitions (one cycle each unless noted):
  - IDLE -> INIT when iStart=1.
  - INIT: A<=iA, B<=iB. -> WAIT_ADDR.
  - WAIT_ADDR -> READ_DATA -> ADD_INIT.
  - ADD_INIT: A+=iS_sub_i1, B+=iS_sub_i2; addresses <= 2,3. -> WAIT_ADDR2.
  - WAIT_ADDR2 -> READ_DATA2 -> XOR_A.
  - XOR_A: A<=A^B; rot_data<=A^B; rot_amt<=B[ROT_VALUE-1:0].
  - ROT_A: A<=rotl(rot_data, rot_amt).
  - ADD_A: A<=A+iS_sub_i1.
  - XOR_B: B<=B^A; rot_data<=B^A; rot_amt<=A[ROT_VALUE-1:0].
  - ROT_B: B<=rotl(rot_data, rot_amt).
  - ADD_B: B<=B+iS_sub_i2.
  - NEXT_ROUND: if round==R, oDone<=1 -> DONE; else round<=round+1, addresses <= 2(round+1), 2(round+1)+1 -> WAIT_ADDR2.
  - DONE: hold all registers until reset.
- Latency: the edge where IDLE sees iStart=1 is edge 0. oDone and the final A,B are registered on edge 4+9R (112 for R=12). Each round takes 9 cycles.
- The key-table data is only consumed in the ADD_INIT, ADD_A and ADD_B states. The address is stable at least 2 cycles before every use.
- iStart dropping mid-operation: the next edge returns the block to reset values; no partial oDone. rst has priority and behaves identically.
- iA/iB changes after INIT are ignored.
- The round counter never wraps: R is the maximum value reached, and CNT_BITS holds R.
- Intermediate A,B values are visible on the outputs during operation; they are only meaningful when oDone=1.

Decomposition:
- Shared package (rc5_pkg): state encodings, and the RC5 magic constants P_W/Q_W per W (for the benches' key-expansion model). The decipher states move here too.
- Sub-module: the existing barrel shifter for the W in use (barrelShifter16/32/64, selected by the barrel16/32/64 define), with iDir=0 selecting left rotate. No other sub-modules.

Test Plan:
- RC5-32/12, zero key (bench-expanded S), iA=0, iB=0 -> at edge 112 oDone=1, oA_encipher=32'hEEDBA521, oB_encipher=32'h6D8F4B15.
- R=1, S={0,0,0,0}, iA=1, iB=0 -> oDone at edge 13, oA=1, oB=2. Also check rotate-by-0 and rotate-by-1 paths.
- Address trace, R=12 -> {0,1} during INIT..ADD_INIT, then {2i,2i+1} for round i, final {24,25}. No address used before it has been stable 2 cycles.
- Round trip, 200 random A,B with random S -> decipher(encipher(A,B)) == (A,B). Rotate amounts 31 and 0 forced at least once.
- iStart dropped at edge 50 -> edge 51 shows IDLE, outputs 0, oDone=0. Reasserting gives a correct result 112 edges later.
- rst pulsed during DONE with iStart high -> all outputs return to reset values next edge, then a full re-run with oDone at edge 112.
